// File: rtl/rmt_pkg.sv
// Shared RMT constants and the container placement function used by both
// the crossbar (extraction) and the PHV assembler (packing).
package rmt_pkg;
  localparam int width_4B = 32;
  localparam int NUM_CONT = 64;
  localparam int META_LEN = 256;
  localparam int PHV_LEN  = 4*8*NUM_CONT + META_LEN;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} fifo_st_e;

  // Bit offset of 4B container i inside a PHV; the tail sits below container 0.
  function automatic int cont_offset(input int i);
    return META_LEN + width_4B*i;
  endfunction
endpackage

// File: rtl/phv_skid_fifo.sv
// Two-entry valid/ready buffer with a registered head and registered ready.
// A full buffer never accepts on the edge it drains, so ready is a pure register.
module phv_skid_fifo
  import rmt_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  fifo_st_e     state_q, state_d;
  logic [W-1:0] head_q, tail_q;
  logic         ready_q;
  logic         push, pop;

  assign push      = in_valid & ready_q;
  assign pop       = (state_q != ST_EMPTY) & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = head_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_FULL;
        else if (pop && !push) state_d = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_FULL);
      case (state_q)
        ST_EMPTY: if (push) head_q <= in_data;
        ST_ONE:   if (push && pop) head_q <= in_data;
        ST_FULL:  if (pop) head_q <= tail_q;
        default:  head_q <= head_q;
      endcase
    end
  end

  // Second slot only matters while FULL, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_ONE && push && !pop) tail_q <= in_data;
  end
endmodule

// File: rtl/phv_assembler.sv
// Action-stage return path: packs ALU container results and the untouched
// metadata tail back into a PHV, buffers it, and counts emitted PHVs.
module phv_assembler #(
  parameter int STAGE_ID = 0,
  parameter int PHV_LEN  = rmt_pkg::PHV_LEN,
  parameter int width_4B = rmt_pkg::width_4B,
  parameter int NUM_CONT = rmt_pkg::NUM_CONT,
  parameter int CNT_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_out_valid,
  input  logic [width_4B*NUM_CONT-1:0] alu_out_4B,
  input  logic [rmt_pkg::META_LEN-1:0] phv_remain_data,
  output logic                         ready_out,
  output logic [PHV_LEN-1:0]           phv_out,
  output logic                         phv_out_valid,
  input  logic                         ready_in,
  output logic [CNT_W-1:0]             phv_count
);
  logic [PHV_LEN-1:0] phv_packed;
  logic [CNT_W-1:0]   cnt_q;

  // STAGE_ID is debug-only; every legal stage index takes this branch.
  if (STAGE_ID >= 0) begin : g_pack
    for (genvar i = 0; i < NUM_CONT; i++) begin : g_cont
      assign phv_packed[rmt_pkg::cont_offset(i) +: width_4B] =
        alu_out_4B[i*width_4B +: width_4B];
    end
    assign phv_packed[rmt_pkg::META_LEN-1:0] = phv_remain_data;
  end

  phv_skid_fifo #(.W(PHV_LEN)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (alu_out_valid),
    .in_data   (phv_packed),
    .in_ready  (ready_out),
    .out_valid (phv_out_valid),
    .out_data  (phv_out),
    .out_ready (ready_in)
  );

  always_ff @(posedge clk) begin
    if (rst)                          cnt_q <= '0;
    else if (phv_out_valid && ready_in) cnt_q <= cnt_q + 1'b1;
  end

  assign phv_count = cnt_q;
endmodule

// File: tb/tb_phv_assembler.sv
// Scoreboard bench for phv_assembler: a queue-based FIFO model fed by the
// stimulus side and checked every cycle by an independent monitor.
module tb_phv_assembler;
  localparam int NC = 64;
  localparam int PL = 32*NC + 256;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            alu_out_valid = 1'b0;
  logic [32*NC-1:0] alu_out_4B = '0;
  logic [255:0]    phv_remain_data = '0;
  logic            ready_out;
  logic [PL-1:0]   phv_out;
  logic            phv_out_valid;
  logic            ready_in = 1'b0;
  logic [CW-1:0]   phv_count;

  always #5 clk = ~clk;

  phv_assembler #(.STAGE_ID(3), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .alu_out_valid(alu_out_valid), .alu_out_4B(alu_out_4B),
    .phv_remain_data(phv_remain_data), .ready_out(ready_out), .phv_out(phv_out),
    .phv_out_valid(phv_out_valid), .ready_in(ready_in), .phv_count(phv_count)
  );

  int checks = 0, errors = 0;
  logic [31:0]   cur_cont [NC];
  logic [255:0]  cur_tail;
  logic [PL-1:0] exp_q [$];
  logic [PL-1:0] last_out = '0;
  int            pops = 0;
  int            rdy_mode = 0;
  bit            track_full = 0, saw_full = 0;

  // Expected PHV: containers stacked above the tail, container 0 lowest.
  function automatic logic [PL-1:0] build_phv();
    logic [PL-1:0] p;
    p = '0;
    p[255:0] = cur_tail;
    for (int i = 0; i < NC; i++) p[256 + 32*i +: 32] = cur_cont[i];
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_phv(input string nm, input logic [PL-1:0] act, input logic [PL-1:0] exp);
    int w;
    checks++;
    if (act !== exp) begin
      errors++;
      w = 0;
      for (int k = PL/32 - 1; k >= 0; k--) if (act[k*32 +: 32] !== exp[k*32 +: 32]) w = k;
      $display("FAIL %s word %0d got %h want %h at %0t", nm, w, act[w*32 +: 32], exp[w*32 +: 32], $time);
    end
  endtask

  // Monitor: compares DUT against the queue model, then advances the model.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pops = 0;
      last_out = '0;
    end else begin
      bit full, do_pop;
      chk("ready_out", {31'd0, ready_out}, {31'd0, exp_q.size() != 2});
      chk("phv_out_valid", {31'd0, phv_out_valid}, {31'd0, exp_q.size() != 0});
      chk("phv_count", {28'd0, phv_count}, pops % 16);
      if (exp_q.size() != 0) chk_phv("head", phv_out, exp_q[0]);
      else                   chk_phv("idle_hold", phv_out, last_out);
      if (track_full && exp_q.size() == 2) saw_full = 1;
      full   = (exp_q.size() == 2);
      do_pop = ready_in && exp_q.size() != 0;
      if (do_pop) begin
        last_out = exp_q.pop_front();
        pops++;
      end
      if (alu_out_valid && !full) exp_q.push_back(build_phv());
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ready_in = 1'b0;
      1:       ready_in = 1'b1;
      default: ready_in = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Present one PHV and hold it until the DUT takes it.
  task automatic send(input bit rnd, input logic [31:0] base, input logic [255:0] tail);
    bit acc;
    for (int i = 0; i < NC; i++) cur_cont[i] = rnd ? $urandom : base + i;
    cur_tail = rnd ? {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} : tail;
    for (int i = 0; i < NC; i++) alu_out_4B[i*32 +: 32] = cur_cont[i];
    phv_remain_data = cur_tail;
    alu_out_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = ready_out;
      @(posedge clk);
      #1;
    end
    alu_out_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    @(posedge clk);
    #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    rdy_mode = 1;
    send(0, 32'hA500_0000, 256'h1234);
    drain();

    rdy_mode = 0;
    fork
      begin
        send(0, 32'hAA00_0000, 256'hA);
        send(0, 32'hBB00_0000, 256'hB);
        send(0, 32'hCC00_0000, 256'hC);
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_ready_low", {31'd0, ready_out}, 32'd0);
        rdy_mode = 1;
      end
    join
    drain();
    chk("bp_count", {28'd0, phv_count}, 32'd4);

    saw_full = 0;
    track_full = 1;
    for (int n = 0; n < 10; n++) send(0, 32'h1000_0000 * n, 256'(n));
    drain();
    track_full = 0;
    chk("stream_no_full", {31'd0, saw_full}, 32'd0);

    rdy_mode = 2;
    for (int n = 0; n < 30; n++) begin
      send(1, 0, '0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    drain();
    chk("wrap_count", {28'd0, phv_count}, 32'(44 % 16));

    rdy_mode = 0;
    send(1, 0, '0);
    send(1, 0, '0);
    @(negedge clk);
    chk("pre_reset_full", {31'd0, ready_out}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, ready_out}, 32'd1);
    @(posedge clk);
    #1 rdy_mode = 1;
    send(0, 32'h5EED_0000, 256'hF00D);
    drain();
    chk("final_count", {28'd0, phv_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
